// File: rtl/burst_drain_pkg.sv
// rtl/burst_drain_pkg.sv - shared drain state and beat types for the burst filler/drain pair
package burst_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } DrainState;

    // Widest beat/length counter any instance may use; instances size theirs with beatWidth().
    localparam int BEAT_MAX_W = 8;
    typedef logic [BEAT_MAX_W-1:0] Beat;

    function automatic int beatWidth(input int chunk);
        return $clog2(chunk) + 1;
    endfunction

endpackage

// File: rtl/burst_out_reg.sv
// rtl/burst_out_reg.sv - registered valid/ready output stage carrying data and SOP/EOP framing
module burst_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             sysClk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadData,
    input  logic             loadSop,
    input  logic             loadEop,
    input  logic             oReady,
    output logic             advance,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    output logic             oSOP,
    output logic             oEOP
);

    assign advance = !oValid || oReady;

    // A stalled word (oValid && !oReady) keeps every field frozen until accepted.
    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            oData  <= '0;
            oValid <= 1'b0;
            oSOP   <= 1'b0;
            oEOP   <= 1'b0;
        end else if (load && advance) begin
            oData  <= loadData;
            oValid <= 1'b1;
            oSOP   <= loadSop;
            oEOP   <= loadEop;
        end else if (oReady) begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: rtl/burst_drain.sv
// rtl/burst_drain.sv - drains buffer_fifo into SOP/EOP-framed chunk bursts with optional flush bursts
module burst_drain
    import burst_drain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CHUNK = 4,
    parameter int CW    = 16
) (
    input  logic             sysClk,
    input  logic             reset,
    input  logic [DEPTH-1:0] fDepth,
    input  logic [WIDTH-1:0] fData,
    input  logic             fValid,
    input  logic             fValidChunk,
    output logic             fReady,
    input  logic             flush,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    output logic             oSOP,
    output logic             oEOP,
    input  logic             oReady,
    output logic             busy,
    output logic [CW-1:0]    burstCount
);

    localparam int BW = beatWidth(CHUNK);
    localparam logic [BW-1:0] CHUNK_LEN = BW'(CHUNK);

    if (CHUNK < 2 || CHUNK > (2 ** DEPTH) - 1 || BW > $bits(Beat)) begin : gBadParam
        $error("burst_drain: CHUNK must satisfy 2 <= CHUNK <= 2**DEPTH-1");
    end

    DrainState      state;
    DrainState      stateNext;
    logic [BW-1:0]  beat;
    logic [BW-1:0]  len;
    logic           advance;
    logic           pop;
    logic           lastBeat;
    logic           startChunk;
    logic           startFlush;

    assign lastBeat   = (beat == len - BW'(1));
    assign startChunk = (state == IDLE) && fValidChunk;
    assign startFlush = (state == IDLE) && !fValidChunk && flush && (fDepth != '0);

    assign busy   = (state != IDLE);
    assign fReady = busy && fValid && advance;
    assign pop    = fReady;

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (startChunk) begin
                    stateNext = BURST;
                end else if (startFlush) begin
                    stateNext = FLUSH;
                end
            end
            BURST, FLUSH: begin
                if (pop && lastBeat) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // len is latched once per burst; beat counts pops, so fValid gaps simply leave it parked.
    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            beat <= '0;
            len  <= '0;
        end else if (startChunk) begin
            beat <= '0;
            len  <= CHUNK_LEN;
        end else if (startFlush) begin
            beat <= '0;
            len  <= BW'(fDepth);
        end else if (pop) begin
            beat <= beat + BW'(1);
        end
    end

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            burstCount <= '0;
        end else if (oValid && oReady && oEOP) begin
            burstCount <= burstCount + CW'(1);
        end
    end

    burst_out_reg #(
        .WIDTH (WIDTH)
    ) uOutReg (
        .sysClk   (sysClk),
        .reset    (reset),
        .load     (pop),
        .loadData (fData),
        .loadSop  (beat == '0),
        .loadEop  (lastBeat),
        .oReady   (oReady),
        .advance  (advance),
        .oData    (oData),
        .oValid   (oValid),
        .oSOP     (oSOP),
        .oEOP     (oEOP)
    );

endmodule

// File: tb/tb_burst_drain.sv
// tb/tb_burst_drain.sv - self-checking bench for burst_drain against a queue-based FIFO and burst model
module tb_burst_drain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CHUNK = 4;
    localparam int CW    = 16;

    logic             sysClk = 1'b0;
    logic             reset;
    logic [DEPTH-1:0] fDepth;
    logic [WIDTH-1:0] fData;
    logic             fValid;
    logic             fValidChunk;
    logic             fReady;
    logic             flush;
    logic [WIDTH-1:0] oData;
    logic             oValid;
    logic             oSOP;
    logic             oEOP;
    logic             oReady;
    logic             busy;
    logic [CW-1:0]    burstCount;

    always #5 sysClk = ~sysClk;

    burst_drain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CHUNK (CHUNK),
        .CW    (CW)
    ) dut (
        .sysClk      (sysClk),
        .reset       (reset),
        .fDepth      (fDepth),
        .fData       (fData),
        .fValid      (fValid),
        .fValidChunk (fValidChunk),
        .fReady      (fReady),
        .flush       (flush),
        .oData       (oData),
        .oValid      (oValid),
        .oSOP        (oSOP),
        .oEOP        (oEOP),
        .oReady      (oReady),
        .busy        (busy),
        .burstCount  (burstCount)
    );

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } Word;

    typedef struct {
        int          n;
        logic [63:0] d;
        logic        fl;
        int          lens [2];
        int          left;
    } Vec;

    int          total = 0;
    int          bad = 0;
    int          mode = 0;
    int          cyc = 0;
    int          expBc = 0;
    int          idleWithData = 0;
    logic [7:0]  fifo [$];
    logic [7:0]  mq [$];
    Word         got [$];
    Word         exq [$];
    logic        pHeld = 1'b0;
    logic        pSop, pEop;
    logic [7:0]  pData;
    Vec          vt [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic driveFifo();
        fDepth      = DEPTH'(fifo.size());
        fData       = (fifo.size() > 0) ? fifo[0] : 8'h00;
        fValidChunk = (fifo.size() >= CHUNK);
        case (mode)
            0:       fValid = (fifo.size() > 0);
            1:       fValid = (fifo.size() > 0) && (cyc % 3 == 0);
            default: fValid = (fifo.size() > 0) && ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic pushWord(input logic [7:0] w);
        fifo.push_back(w);
        mq.push_back(w);
    endtask

    task automatic step(input logic r, input logic fl);
        logic popNow;
        @(negedge sysClk);
        oReady = r;
        flush  = fl;
        driveFifo();
        #1;
        if (pHeld) begin
            check("hold", {oValid, oSOP, oEOP, oData}, {1'b1, pSop, pEop, pData});
        end
        pHeld = oValid && !oReady;
        pSop  = oSOP;
        pEop  = oEOP;
        pData = oData;
        if (!busy && fifo.size() > 0) idleWithData++;
        if (oValid && oReady) begin
            Word w;
            w.d = oData;
            w.sop = oSOP;
            w.eop = oEOP;
            got.push_back(w);
        end
        popNow = fReady;
        @(posedge sysClk);
        #1;
        if (popNow && fifo.size() > 0) fifo.delete(0);
        cyc++;
    endtask

    // Expected stream: consecutive model-FIFO words cut into bursts of the given lengths.
    task automatic expectBurst(input int l);
        for (int j = 0; j < l; j++) begin
            Word w;
            w.d = mq.pop_front();
            w.sop = (j == 0);
            w.eop = (j == l - 1);
            exq.push_back(w);
        end
        if (l > 0) expBc++;
    endtask

    task automatic compareGot(input string name);
        check({name, ".count"}, got.size(), exq.size());
        for (int i = 0; i < got.size() && i < exq.size(); i++) begin
            check({name, ".word"}, {got[i].d, got[i].sop, got[i].eop},
                  {exq[i].d, exq[i].sop, exq[i].eop});
        end
        got.delete();
        exq.delete();
        check({name, ".burstCount"}, burstCount, expBc);
    endtask

    initial begin
        reset = 1'b0;
        oReady = 1'b0;
        flush = 1'b0;
        driveFifo();
        #12;
        check("rst.outs", {oValid, oSOP, oEOP, oData}, 11'h0);
        check("rst.busy", {busy, fReady}, 2'b00);
        check("rst.burstCount", burstCount, 0);
        @(negedge sysClk);
        reset = 1'b1;

        vt[0] = '{5, 64'h945DFD4F41000000, 1'b0, '{4, 0}, 1};
        vt[1] = '{0, 64'h0,                1'b1, '{1, 0}, 0};
        vt[2] = '{3, 64'h1122330000000000, 1'b0, '{0, 0}, 3};
        vt[3] = '{0, 64'h0,                1'b1, '{3, 0}, 0};
        vt[4] = '{0, 64'h0,                1'b1, '{0, 0}, 0};
        vt[5] = '{6, 64'hA0A1A2A3A4A50000, 1'b1, '{4, 2}, 0};
        vt[6] = '{8, 64'h0123456789ABCDEF, 1'b0, '{4, 4}, 0};

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < vt[v].n; k++) pushWord(vt[v].d[63 - 8 * k -: 8]);
            for (int c = 0; c < 30; c++) step(1'b1, vt[v].fl);
            expectBurst(vt[v].lens[0]);
            expectBurst(vt[v].lens[1]);
            compareGot($sformatf("vec%0d", v));
            check($sformatf("vec%0d.left", v), fifo.size(), vt[v].left);
            check($sformatf("vec%0d.idle", v), {busy, oValid}, 2'b00);
        end

        // oReady 1,0,0 pattern: stalled words hold, one idle cycle separates the bursts.
        idleWithData = 0;
        for (int k = 0; k < 8; k++) pushWord(8'h30 + 8'(k));
        for (int c = 0; c < 200; c++) begin
            if (got.size() >= 8 && fifo.size() == 0 && !busy) break;
            step(c % 3 == 0, 1'b0);
        end
        expectBurst(4);
        expectBurst(4);
        compareGot("stall");
        check("stall.idleGap", idleWithData, 2);

        // Block-RAM style FIFO: fValid pulses while the chunk flag is already up.
        mode = 1;
        for (int k = 0; k < 4; k++) pushWord(8'hC0 + 8'(k));
        for (int c = 0; c < 100; c++) begin
            if (got.size() >= 4 && !busy && !oValid) break;
            step(1'b1, 1'b0);
        end
        mode = 0;
        expectBurst(4);
        compareGot("bram");

        // Reset after the second word is accepted: three words have left the FIFO by then.
        for (int k = 0; k < 8; k++) pushWord(8'h50 + 8'(k));
        for (int c = 0; c < 20 && got.size() < 2; c++) step(1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst.outs", {oValid, oSOP, oEOP, oData}, 11'h0);
        check("midrst.busy", {busy, fReady}, 2'b00);
        check("midrst.burstCount", burstCount, 0);
        got.delete();
        for (int k = 0; k < 3; k++) void'(mq.pop_front());
        expBc = 0;
        pHeld = 1'b0;
        step(1'b1, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 30; c++) step(1'b1, 1'b0);
        expectBurst(4);
        compareGot("postrst");
        for (int c = 0; c < 10; c++) step(1'b1, 1'b1);
        expectBurst(1);
        compareGot("postrst.flush");

        // Random contents, random backpressure, random flush, fValid dropouts.
        mode = 2;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(13, 1);
            for (int k = 0; k < n; k++) pushWord(8'($urandom));
            for (int c = 0; c < 400; c++) begin
                if (fifo.size() == 0 && !busy && !oValid) break;
                step($urandom_range(3) != 0, 1'($urandom_range(1)));
            end
            for (int b = 0; b < n / CHUNK; b++) expectBurst(CHUNK);
            expectBurst(n % CHUNK);
            compareGot($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
